// File: rtl/bias_ctrl_pkg.sv
// Shared types and default sizing for the bias-stage sequencer.
package bias_ctrl_pkg;

    localparam int unsigned DEF_LANES = 8;
    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_ROWS  = 8;
    localparam int unsigned ROW_W     = DEF_LANES * DEF_DW;

    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/bias_ctrl_if.sv
// Host/array/bias-unit signal bundle for bias_ctrl.
// Optional BIAS_CTRL_BYPASS_EN adds the per-tile bypass input.
interface bias_ctrl_if #(
    parameter int unsigned LANES = bias_ctrl_pkg::DEF_LANES,
    parameter int unsigned DW    = bias_ctrl_pkg::DEF_DW,
    parameter int unsigned ROWS  = bias_ctrl_pkg::DEF_ROWS
);
    localparam int unsigned W  = LANES * DW;
    localparam int unsigned CW = $clog2(ROWS + 1);

    logic          bias_load_valid;
    logic [W-1:0]  bias_load_data;
    logic          bias_load_ready;
    logic          tile_start;
    logic          tile_abort;
    logic          array_valid;
    logic [W-1:0]  array_output;
    logic          array_ready;
    logic [W-1:0]  bias_vec;
    logic [W-1:0]  bias_row;
    logic          bias_add_en;
    logic          out_valid;
    logic          out_ready;
    logic          tile_done;
    logic          busy;
    logic [CW-1:0] row_count;
`ifdef BIAS_CTRL_BYPASS_EN
    logic          bypass;
`endif

    modport master (
`ifdef BIAS_CTRL_BYPASS_EN
        output bypass,
`endif
        output bias_load_valid, bias_load_data, tile_start, tile_abort,
        output array_valid, array_output, out_ready,
        input  bias_load_ready, array_ready, bias_vec, bias_row, bias_add_en,
        input  out_valid, tile_done, busy, row_count
    );

    modport slave (
`ifdef BIAS_CTRL_BYPASS_EN
        input  bypass,
`endif
        input  bias_load_valid, bias_load_data, tile_start, tile_abort,
        input  array_valid, array_output, out_ready,
        output bias_load_ready, array_ready, bias_vec, bias_row, bias_add_en,
        output out_valid, tile_done, busy, row_count
    );

endinterface

// File: rtl/bias_row_fifo.sv
// Two-entry row FIFO with occupancy count and synchronous flush.
module bias_row_fifo #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop  && (r_count != 2'd0);
    assign w_push = i_push && (r_count != 2'd2);

    // Flush drops any push issued in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/bias_ctrl.sv
// Per-row bias stage sequencer: holds the bias vector and meters one tile of rows.
// Optional BIAS_CTRL_BYPASS_EN lets a tile run with bias addition suppressed.
module bias_ctrl
    import bias_ctrl_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned ROWS  = DEF_ROWS
) (
    input  logic clk,
    input  logic rst,
    bias_ctrl_if.slave bus
);

    localparam int unsigned W  = LANES * DW;
    localparam int unsigned CW = $clog2(ROWS + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_bias_vec;
    logic [W-1:0]  w_bias_nxt;
    logic [CW-1:0] r_row_count;
    logic [CW-1:0] w_row_count_nxt;
    logic          r_tile_done;
    logic          w_tile_done_nxt;
    logic          r_bypass;
    logic          w_bypass_nxt;
    logic          w_flush;
    logic          w_load_hs;
    logic          w_array_ready;
    logic          w_accept;
    logic          w_out_valid;
    logic          w_pop;
    logic          w_start_bypass;
    logic          w_active;
    logic [1:0]    w_fifo_count;
    logic [W-1:0]  w_head;

`ifdef BIAS_CTRL_BYPASS_EN
    assign w_start_bypass = bus.bypass;
`else
    assign w_start_bypass = 1'b0;
`endif

    assign w_active      = (r_state == RUN) || (r_state == DRAIN);
    assign w_load_hs     = bus.bias_load_valid && ((r_state == IDLE) || (r_state == ARMED));
    assign w_array_ready = (r_state == RUN) && (w_fifo_count != 2'd2) && (r_row_count < CW'(ROWS));
    assign w_accept      = bus.array_valid && w_array_ready;
    assign w_out_valid   = (w_fifo_count != 2'd0);
    assign w_pop         = w_out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bias_vec  <= '0;
            r_row_count <= '0;
            r_tile_done <= 1'b0;
            r_bypass    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bias_vec  <= w_bias_nxt;
            r_row_count <= w_row_count_nxt;
            r_tile_done <= w_tile_done_nxt;
            r_bypass    <= w_bypass_nxt;
        end
    end

    // Load beats start in IDLE/ARMED; abort beats everything in RUN/DRAIN.
    always_comb begin
        w_state_nxt     = r_state;
        w_bias_nxt      = r_bias_vec;
        w_row_count_nxt = r_row_count;
        w_tile_done_nxt = 1'b0;
        w_bypass_nxt    = r_bypass;
        w_flush         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_load_hs) begin
                    w_bias_nxt  = bus.bias_load_data;
                    w_state_nxt = ARMED;
                end else if (bus.tile_start && w_start_bypass) begin
                    w_row_count_nxt = '0;
                    w_bypass_nxt    = 1'b1;
                    w_state_nxt     = RUN;
                end
            end
            ARMED: begin
                if (w_load_hs) begin
                    w_bias_nxt = bus.bias_load_data;
                end else if (bus.tile_start) begin
                    w_row_count_nxt = '0;
                    w_bypass_nxt    = w_start_bypass;
                    w_state_nxt     = RUN;
                end
            end
            RUN: begin
                if (bus.tile_abort) begin
                    w_flush         = 1'b1;
                    w_row_count_nxt = '0;
                    w_state_nxt     = ARMED;
                end else if (w_accept) begin
                    w_row_count_nxt = r_row_count + CW'(1);
                    if (r_row_count == CW'(ROWS - 1)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.tile_abort) begin
                    w_flush         = 1'b1;
                    w_row_count_nxt = '0;
                    w_state_nxt     = ARMED;
                end else if (w_fifo_count == 2'd0) begin
                    w_tile_done_nxt = 1'b1;
                    w_state_nxt     = ARMED;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    bias_row_fifo #(.W(W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (bus.array_output),
        .o_head  (w_head),
        .o_count (w_fifo_count)
    );

    assign bus.bias_load_ready = (r_state == IDLE) || (r_state == ARMED);
    assign bus.array_ready     = w_array_ready;
    assign bus.bias_vec        = r_bias_vec;
    assign bus.bias_row        = w_head;
    assign bus.out_valid       = w_out_valid;
    assign bus.bias_add_en     = w_out_valid && w_active && !r_bypass;
    assign bus.tile_done       = r_tile_done;
    assign bus.busy            = w_active;
    assign bus.row_count       = r_row_count;

endmodule

// File: tb/tb_bias_ctrl.sv
// Directed bench for bias_ctrl with a queue-based reference model checked every cycle.
module tb_bias_ctrl;

    localparam int ROWS = int'(bias_ctrl_pkg::DEF_ROWS);
    typedef bias_ctrl_pkg::row_t row_t;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bias_ctrl_if bus ();
    bias_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int   checks = 0;
    int   errors = 0;
    int   m_mode = M_IDLE;
    row_t m_bias = '0;
    row_t m_q[$];
    int   m_rows = 0;
    bit   m_done = 1'b0;
    bit   m_byp  = 1'b0;
    int   n_out  = 0;
    int   n_add  = 0;
    int   n_done = 0;
    row_t got[$];
    row_t row_vec [8];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: advances on every clock edge from the inputs seen there.
    task automatic model_step();
        bit load_hs, arr_rdy, acc, pop, start_byp;
        load_hs   = bus.bias_load_valid && (m_mode == M_IDLE || m_mode == M_ARMED);
        arr_rdy   = (m_mode == M_RUN) && (m_q.size() < 2) && (m_rows < ROWS);
        acc       = bus.array_valid && arr_rdy;
        pop       = (m_q.size() != 0) && bus.out_ready;
        start_byp = 1'b0;
`ifdef BIAS_CTRL_BYPASS_EN
        start_byp = bus.bypass;
`endif
        m_done = 1'b0;
        if (m_mode == M_IDLE) begin
            if (load_hs) begin
                m_bias = bus.bias_load_data; m_mode = M_ARMED;
            end else if (bus.tile_start && start_byp) begin
                m_rows = 0; m_byp = 1'b1; m_mode = M_RUN;
            end
        end else if (m_mode == M_ARMED) begin
            if (load_hs) m_bias = bus.bias_load_data;
            else if (bus.tile_start) begin
                m_rows = 0; m_byp = start_byp; m_mode = M_RUN;
            end
        end else if (bus.tile_abort) begin
            m_q.delete(); m_rows = 0; m_mode = M_ARMED;
        end else if (m_mode == M_RUN) begin
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(bus.array_output); m_rows++;
            end
            if (m_rows == ROWS) m_mode = M_DRAIN;
        end else begin
            if (m_q.size() == 0) begin
                m_done = 1'b1; m_mode = M_ARMED;
            end else if (pop) void'(m_q.pop_front());
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = M_IDLE; m_bias = '0; m_q.delete();
                m_rows = 0; m_done = 1'b0; m_byp = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // Every-cycle comparison against the model, plus handshake bookkeeping.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
            if (m_q.size() != 0) chk("bias_row", bus.bias_row, m_q[0]);
            chk("bias_vec", bus.bias_vec, m_bias);
            chk("row_count", 64'(bus.row_count), 64'(m_rows));
            chk("array_ready", 64'(bus.array_ready),
                64'((m_mode == M_RUN) && (m_q.size() < 2) && (m_rows < ROWS)));
            chk("bias_load_ready", 64'(bus.bias_load_ready),
                64'(m_mode == M_IDLE || m_mode == M_ARMED));
            chk("busy", 64'(bus.busy), 64'(m_mode == M_RUN || m_mode == M_DRAIN));
            chk("tile_done", 64'(bus.tile_done), 64'(m_done));
            chk("bias_add_en", 64'(bus.bias_add_en),
                64'((m_mode == M_RUN || m_mode == M_DRAIN) && (m_q.size() != 0) && !m_byp));
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                got.push_back(bus.bias_row);
                if (bus.bias_add_en) n_add++;
            end
            if (bus.tile_done) n_done++;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int from, int to);
        int idx;
        int budget;
        bit acc;
        idx    = from;
        budget = 0;
        while (idx < to && budget < 100) begin
            bus.array_valid  = 1'b1;
            bus.array_output = row_vec[idx];
            acc = bus.array_ready;
            tick();
            if (acc) idx++;
            budget++;
        end
        bus.array_valid = 1'b0;
        if (idx < to) chk("send_timeout", 64'(idx), 64'(to));
    endtask

    task automatic wait_done(int budget);
        int start;
        int k;
        start = n_done;
        k     = 0;
        while (n_done == start && k < budget) begin
            tick();
            k++;
        end
        if (n_done == start) chk("done_timeout", 64'(n_done - start), 64'(1));
    endtask

    task automatic start_tile();
        bus.tile_start = 1'b1;
        tick();
        bus.tile_start = 1'b0;
    endtask

    task automatic clear_counts();
        n_out = 0; n_add = 0; n_done = 0; got.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.bias_load_valid = 1'b0;
        bus.bias_load_data  = '0;
        bus.tile_start      = 1'b0;
        bus.tile_abort      = 1'b0;
        bus.array_valid     = 1'b0;
        bus.array_output    = '0;
        bus.out_ready       = 1'b0;
`ifdef BIAS_CTRL_BYPASS_EN
        bus.bypass          = 1'b0;
`endif
        #1 rst = 1'b1;
        #1;
        chk("rst_bias_vec", bus.bias_vec, 64'h0);
        chk("rst_row_count", 64'(bus.row_count), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        tick(2);
        rst = 1'b0;
        tick();

        // tile_start is ignored while no bias is loaded
        start_tile();
        tick();
        chk("idle_start_ignored", 64'(bus.busy), 64'd0);

        // Basic tile with a constant row stream
        bus.bias_load_valid = 1'b1;
        bus.bias_load_data  = 64'h1111111111111111;
        tick();
        bus.bias_load_valid = 1'b0;
        chk("load_bias", bus.bias_vec, 64'h1111111111111111);
        clear_counts();
        bus.out_ready = 1'b1;
        start_tile();
        chk("t1_busy", 64'(bus.busy), 64'd1);
        chk("t1_row_count0", 64'(bus.row_count), 64'd0);
        for (int i = 0; i < 8; i++) row_vec[i] = 64'hDEADBEEFBAD1BAD1;
        send(0, 8);
        wait_done(40);
        chk("t1_out_hs", 64'(n_out), 64'd8);
        chk("t1_add_en", 64'(n_add), 64'd8);
        chk("t1_row_count", 64'(bus.row_count), 64'd8);
        chk("t1_bias_vec", bus.bias_vec, 64'h1111111111111111);
        chk("t1_armed", 64'(bus.bias_load_ready), 64'd1);
        tick(3);
        chk("t1_one_done", 64'(n_done), 64'd1);

        // Backpressure: two rows fill the FIFO, order kept once drained
        for (int i = 0; i < 8; i++) row_vec[i] = 64'h0123456789ABCD00 + 64'(i);
        clear_counts();
        bus.out_ready = 1'b0;
        start_tile();
        send(0, 2);
        tick(3);
        chk("bp_array_ready", 64'(bus.array_ready), 64'd0);
        chk("bp_row_count", 64'(bus.row_count), 64'd2);
        chk("bp_head", bus.bias_row, 64'h0123456789ABCD00);
        chk("bp_no_out", 64'(n_out), 64'd0);
        bus.out_ready = 1'b1;
        send(2, 8);
        wait_done(40);
        chk("bp_out_hs", 64'(n_out), 64'd8);
        for (int i = 0; i < 8; i++)
            chk("bp_order", (i < got.size()) ? got[i] : 64'h0, 64'h0123456789ABCD00 + 64'(i));

        // Load and start together: load wins, tile not started
        bus.bias_load_valid = 1'b1;
        bus.bias_load_data  = 64'h2222222222222222;
        bus.tile_start      = 1'b1;
        tick();
        bus.bias_load_valid = 1'b0;
        bus.tile_start      = 1'b0;
        chk("ls_bias_vec", bus.bias_vec, 64'h2222222222222222);
        tick(2);
        chk("ls_not_busy", 64'(bus.busy), 64'd0);

        // Abort after three rows with one still buffered
        clear_counts();
        bus.out_ready = 1'b1;
        start_tile();
        send(0, 3);
        bus.out_ready = 1'b0;
        chk("ab_row_count3", 64'(bus.row_count), 64'd3);
        chk("ab_buffered", 64'(bus.out_valid), 64'd1);
        bus.tile_abort = 1'b1;
        tick();
        bus.tile_abort = 1'b0;
        chk("ab_flushed", 64'(bus.out_valid), 64'd0);
        chk("ab_row_count0", 64'(bus.row_count), 64'd0);
        chk("ab_armed", 64'(bus.bias_load_ready), 64'd1);
        tick(4);
        chk("ab_no_done", 64'(n_done), 64'd0);
        bus.out_ready = 1'b1;
        start_tile();
        chk("ab_next_rc", 64'(bus.row_count), 64'd0);
        send(0, 8);
        wait_done(40);
        chk("ab_next_done", 64'(n_done), 64'd1);
        chk("ab_next_rows", 64'(bus.row_count), 64'd8);

        // Asynchronous reset mid-tile with one row buffered
        bus.out_ready = 1'b0;
        start_tile();
        send(0, 1);
        chk("mr_buffered", 64'(bus.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_row_count", 64'(bus.row_count), 64'd0);
        chk("mr_bias_vec", bus.bias_vec, 64'h0);
        chk("mr_busy", 64'(bus.busy), 64'd0);
        tick();
        rst = 1'b0;
        tick();

`ifdef BIAS_CTRL_BYPASS_EN
        // Bypass tile started from IDLE with no bias loaded
        clear_counts();
        bus.out_ready  = 1'b1;
        bus.bypass     = 1'b1;
        bus.tile_start = 1'b1;
        tick();
        bus.tile_start = 1'b0;
        bus.bypass     = 1'b0;
        chk("by_busy", 64'(bus.busy), 64'd1);
        send(0, 8);
        wait_done(40);
        chk("by_out_hs", 64'(n_out), 64'd8);
        chk("by_no_add", 64'(n_add), 64'd0);
        chk("by_done", 64'(n_done), 64'd1);
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
